// File: rtl/lsu_mem_sequencer_pkg.sv
// Shared RAM access modes, sequencer state encoding, latched request record and split-count helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package lsu_mem_sequencer_pkg;

    localparam logic [1:0] RAM_MODE_BYTE    = 2'd0;
    localparam logic [1:0] RAM_MODE_HALF    = 2'd1;
    localparam logic [1:0] RAM_MODE_WORD    = 2'd2;
    localparam logic [1:0] RAM_MODE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DRAIN  = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  mode;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Index of the last piece: 0 for one RAM access, 1 for two bytes, 3 for four bytes.
    function automatic logic [1:0] piece_last(input logic [1:0] mode,
                                              input logic [1:0] ofs,
                                              input logic       force_split);
        logic [1:0] last;
        last = 2'd0;
        case (mode)
            RAM_MODE_HALF: if (force_split || ofs == 2'd3) last = 2'd1;
            RAM_MODE_WORD: if (force_split || ofs != 2'd0) last = 2'd3;
            default:       last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result formatting: single-piece data passes through, split half is zero/sign-extended from bit 15.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
    import lsu_mem_sequencer_pkg::*;
(
    input  logic [31:0] lanes,
    input  logic [1:0]  mode,
    input  logic        sgn,
    input  logic        split,
    output logic [31:0] rdata
);

    // The RAM already extends single-piece reads, and a split word fills all four lanes.
    always_comb begin
        rdata = lanes;
        if (split && mode == RAM_MODE_HALF) begin
            rdata = {{16{sgn & lanes[15]}}, lanes[15:0]};
        end
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer in front of the data RAM; splits misaligned half/word accesses into byte pieces.
// Latency: aligned store 2, aligned load 3, split store 1+n, split load 2+n cycles from accept; illegal 1.
// Backpressure: req_ready only in IDLE (one request in flight); response is a pulse with no backpressure.
module lsu_mem_sequencer
    import lsu_mem_sequencer_pkg::*;
#(
    parameter bit FORCE_SPLIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [1:0]  ram_mode,
    output logic        ram_signed,
    input  logic [31:0] ram_rdata
);

    lsu_state_t  state, state_nxt;
    lsu_req_t    req_q;
    logic [1:0]  last_q;
    logic [1:0]  k_q;
    logic [1:0]  k_prev;
    logic        err_q;
    logic [31:0] lanes_q;
    logic [31:0] align_rdata;
    logic [7:0]  wbyte;
    logic        split;
    logic        accept;

    assign accept = req_valid && req_ready;
    assign split  = (last_q != 2'd0);
    assign k_prev = k_q - 2'd1;
    assign wbyte  = req_q.wdata[{k_q, 3'b000} +: 8];

    lsu_load_align u_align (
        .lanes (lanes_q),
        .mode  (req_q.mode),
        .sgn   (req_q.sgn),
        .split (split),
        .rdata (align_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM port outputs are decoded from state so reset drops ram_we without waiting for a clock.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = 32'd0;
        ram_wdata  = 32'd0;
        ram_mode   = RAM_MODE_BYTE;
        ram_signed = 1'b0;
        case (state)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (req_mode == RAM_MODE_ILLEGAL) ? LSU_RESP : LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                ram_we = req_q.we;
                if (split) begin
                    ram_addr  = req_q.addr + {30'd0, k_q};
                    ram_wdata = {24'd0, wbyte};
                end else begin
                    ram_mode   = req_q.mode;
                    ram_addr   = req_q.addr;
                    ram_signed = req_q.sgn;
                    ram_wdata  = req_q.wdata;
                end
                if (k_q == last_q) begin
                    state_nxt = req_q.we ? LSU_RESP : LSU_DRAIN;
                end
            end
            LSU_DRAIN: begin
                state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!req_q.we && !err_q) begin
                    resp_rdata = align_rdata;
                end
                state_nxt = LSU_IDLE;
            end
            default: begin
                state_nxt = LSU_IDLE;
            end
        endcase
    end

    // Read data trails each issue by one cycle, so piece k-1 lands while piece k is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            last_q  <= 2'd0;
            k_q     <= 2'd0;
            err_q   <= 1'b0;
            lanes_q <= 32'd0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        req_q.we    <= req_we;
                        req_q.mode  <= req_mode;
                        req_q.sgn   <= req_signed;
                        req_q.addr  <= req_addr;
                        req_q.wdata <= req_wdata;
                        last_q      <= piece_last(req_mode, req_addr[1:0], FORCE_SPLIT);
                        k_q         <= 2'd0;
                        err_q       <= (req_mode == RAM_MODE_ILLEGAL);
                        lanes_q     <= 32'd0;
                    end
                end
                LSU_ACCESS: begin
                    k_q <= k_q + 2'd1;
                    if (!req_q.we && k_q != 2'd0) begin
                        lanes_q[{k_prev, 3'b000} +: 8] <= ram_rdata[7:0];
                    end
                end
                LSU_DRAIN: begin
                    if (split) begin
                        lanes_q[{last_q, 3'b000} +: 8] <= ram_rdata[7:0];
                    end else begin
                        lanes_q <= ram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: byte-addressed RAM model, vector table with scoreboard, hand-written corner sequences.
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        ram_we, ram_signed;
    logic [31:0] ram_addr, ram_wdata;
    logic [1:0]  ram_mode;
    logic [31:0] ram_rdata = 32'd0;

    lsu_mem_sequencer #(.FORCE_SPLIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_mode   (req_mode),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_mode   (ram_mode),
        .ram_signed (ram_signed),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  mode;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_writes;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
        int          wstart;
        int          writes;
        int          id;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mode;
    } wr_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    wr_t         wlog[$];
    logic [7:0]  mem [logic [31:0]];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    function automatic logic [7:0] rd8(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM model: registered read (data one cycle after address), byte/half/word writes, 32-bit address wrap.
    initial begin : ram_model
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] r;
        forever begin
            @(posedge clk);
            b0 = rd8(ram_addr);
            b1 = rd8(ram_addr + 32'd1);
            b2 = rd8(ram_addr + 32'd2);
            b3 = rd8(ram_addr + 32'd3);
            case (ram_mode)
                2'd0:    r = {{24{ram_signed & b0[7]}}, b0};
                2'd1:    r = {{16{ram_signed & b1[7]}}, b1, b0};
                default: r = {b3, b2, b1, b0};
            endcase
            ram_rdata <= r;
            if (ram_we) begin
                wlog.push_back('{cyc, ram_addr, ram_wdata, ram_mode});
                mem[ram_addr] = ram_wdata[7:0];
                if (ram_mode != 2'd0) mem[ram_addr + 32'd1] = ram_wdata[15:8];
                if (ram_mode == 2'd2) begin
                    mem[ram_addr + 32'd2] = ram_wdata[23:16];
                    mem[ram_addr + 32'd3] = ram_wdata[31:24];
                end
            end
            cyc++;
        end
    end

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_rdata", e.id), resp_rdata, e.rdata);
                check($sformatf("v%0d_err", e.id), 32'(resp_err), 32'(e.err));
                check($sformatf("v%0d_latency", e.id), 32'(cyc - e.acc_cyc), 32'(e.lat));
                check($sformatf("v%0d_ram_writes", e.id), 32'(wlog.size() - e.wstart), 32'(e.writes));
            end
        end
    end

    task automatic send(input vec_t v, input int id, output int acc);
        int guard;
        guard = 0;
        acc = -1;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check($sformatf("v%0d_ready_timeout", id), 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = v.we;
        req_mode   = v.mode;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        acc = cyc;
        sb.push_back('{v.exp_rdata, v.exp_err, cyc, v.exp_lat, wlog.size(), v.exp_writes, id});
        @(negedge clk);
        // Garbage on the request bus while busy must be ignored.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_mode   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic split_store_check(input logic [31:0] addr, input logic [31:0] wdata, input int id);
        vec_t        v;
        wr_t         w;
        int          acc, ws;
        logic [31:0] sh;
        v = '{1'b1, 2'd2, 1'b0, addr, wdata, 32'd0, 1'b0, 5, 4};
        ws = wlog.size();
        send(v, id, acc);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            if (ws + k < wlog.size()) begin
                w  = wlog[ws + k];
                sh = wdata >> (8 * k);
                check($sformatf("h%0d_piece%0d_addr", id, k), w.addr, addr + 32'(k));
                check($sformatf("h%0d_piece%0d_byte", id, k), 32'(w.wdata[7:0]), 32'(sh[7:0]));
                check($sformatf("h%0d_piece%0d_cycle", id, k), 32'(w.cyc), 32'(acc + 1 + k));
                check($sformatf("h%0d_piece%0d_mode", id, k), 32'(w.mode), 32'd0);
            end else begin
                check($sformatf("h%0d_piece%0d_missing", id, k), 32'(wlog.size()), 32'(ws + 4));
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int   acc, ws;
        vec_t v;
        wr_t  w;
        req_valid = 1'b0; req_we = 1'b0; req_mode = 2'd0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;

        //            we    mode  sgn   addr           wdata          rdata          err   lat wr
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h1122_3344, 1'b0, 3, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'hDEAD_BE80, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_0104, 32'h1234_56FF, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0103, 32'h0,         32'hFFFF_FF80, 1'b0, 4, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0103, 32'h0,         32'h0000_FF80, 1'b0, 4, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0201, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 5, 4});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0201, 32'h0,         32'hAABB_CCDD, 1'b0, 6, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_2233, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0104, 32'h0,         32'h0000_00FF, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h8022_3344, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 2'd3, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 1, 0});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0104, 32'h0,         32'h0000_00FF, 1'b0, 3, 0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_02FF, 32'h1234_BEEF, 32'h0000_0000, 1'b0, 3, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_02FF, 32'h0,         32'h0000_BEEF, 1'b0, 4, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_02FF, 32'h0,         32'hFFFF_BEEF, 1'b0, 4, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h5566_7788, 32'h0000_0000, 1'b0, 5, 4});
        vecs.push_back('{1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'h0,         32'h5566_7788, 1'b0, 6, 0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_5566, 1'b0, 3, 0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h9999_CAFE, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_5566, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0401, 32'h0,         32'h0000_0000, 1'b0, 3, 0});

        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        check("rst_ram_we",     32'(ram_we),     32'd0);
        check("rst_ram_addr",   ram_addr,        32'd0);
        check("rst_ram_wdata",  ram_wdata,       32'd0);
        check("rst_ram_mode",   32'(ram_mode),   32'd0);
        check("rst_ram_signed", 32'(ram_signed), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) send(vecs[i], i, acc);
        wait_idle();

        // Aligned word store: a single RAM write, in the cycle after accept.
        v = '{1'b1, 2'd2, 1'b0, 32'h0000_0600, 32'h1122_3344, 32'h0, 1'b0, 2, 1};
        ws = wlog.size();
        send(v, 100, acc);
        wait_idle();
        if (wlog.size() > ws) begin
            w = wlog[ws];
            check("h100_addr",  w.addr,        32'h0000_0600);
            check("h100_wdata", w.wdata,       32'h1122_3344);
            check("h100_mode",  32'(w.mode),   32'd2);
            check("h100_cycle", 32'(w.cyc),    32'(acc + 1));
        end else begin
            check("h100_missing", 32'(wlog.size()), 32'(ws + 1));
        end

        split_store_check(32'h0000_0501, 32'h0A0B_0C0D, 101);
        split_store_check(32'hFFFF_FFFF, 32'h0F1E_2D3C, 102);

        // Reset while the second piece of a split store is on the RAM port.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_mode = 2'd2; req_signed = 1'b0;
        req_addr = 32'h0000_0301; req_wdata = 32'h0102_0304;
        check("h103_ready_at_issue", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("h103_piece1_we",   32'(ram_we), 32'd1);
        check("h103_piece1_addr", ram_addr,    32'h0000_0302);
        rst_n = 1'b0;
        #1;
        check("h103_async_we_drop", 32'(ram_we),    32'd0);
        check("h103_async_ready",   32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("h103_ready_after", 32'(req_ready),  32'd1);
        check("h103_no_resp",     32'(resp_valid), 32'd0);
        v = '{1'b0, 2'd0, 1'b0, 32'h0000_0301, 32'h0, 32'h0000_0004, 1'b0, 3, 0};
        send(v, 104, acc);
        v = '{1'b0, 2'd0, 1'b0, 32'h0000_0302, 32'h0, 32'h0000_0000, 1'b0, 3, 0};
        send(v, 105, acc);
        v = '{1'b1, 2'd2, 1'b0, 32'h0000_0302, 32'h7654_3210, 32'h0, 1'b0, 5, 4};
        send(v, 106, acc);
        v = '{1'b0, 2'd2, 1'b0, 32'h0000_0302, 32'h0, 32'h7654_3210, 1'b0, 6, 0};
        send(v, 107, acc);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
